z80_bus_irq_ctrl: RTL and testbench
===================================

Name: z80_bus_irq_ctrl

Overview:
- Parametrised bus/interrupt companion that sits beside a T80s core.
- Decodes raw active-low Z80 bus strobes into active-high strobes and latches edge-triggered requests from NUM_IRQ sources and one NMI source.
- Drives INT_n/NMI_n, detects acknowledge cycles (IM1 fetch-at-0x0038 or IM2/IM0 vector cycle), and supplies the vector byte.
- Inserts programmable memory/IO wait states.

Parameters:
- NUM_IRQ, 4: number of maskable request channels (1..8).
- MODE, 1: 0 = IM1 (ack is opcode fetch at 0x0038, no vector); 1 = vectored (ack is M1&IORQ cycle, vector driven).
- VEC_BASE, 8'hE0: vector for channel i is VEC_BASE + 2*i, 8-bit wrap.
- WAIT_MEM, 0: clk_en ticks of WAIT_n low per memory access (0..15).
- WAIT_IO, 0: clk_en ticks of WAIT_n low per IO access (0..15).

Ports:
- clk in 1: system clock; only clock.
- reset in 1: synchronous, active-high.
- clk_en in 1: CPU clock enable, same as fed to T80s CEN.
- cpu_a in 16: CPU address.
- cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_m1_n in 1 each: raw T80s strobes.
- irq_req in NUM_IRQ: request lines; rising edge requests.
- irq_clr in NUM_IRQ: software clear of pending bits.
- nmi_req in 1: NMI request; rising edge requests.
- cpu_int_n out 1: to T80s INT_n.
- cpu_nmi_n out 1: to T80s NMI_n.
- cpu_wait_n out 1: to T80s WAIT_n.
- vec_oe out 1: high while vector must be muxed onto CPU DI.
- vec_out out 8: vector byte.
- irq_pend out NUM_IRQ: pending bits.
- irq_ack out NUM_IRQ: one-clk ack pulse per channel.
- nmi_ack out 1: one-clk ack pulse.
- mx, ix, rd, wr, m1 out 1 each: decoded strobes.

Behaviour:
- Decode, combinational:
  - mx = ~mreq_n & rfsh_n.
  - ix = ~iorq_n & m1_n (IO, excludes int-ack).
  - rd = ~rd_n; wr = ~wr_n; m1 = ~m1_n.
- Reset:
  - Cleared: pending, nmi_pend, wait counter, acks, vec_oe.
  - Driven high: cpu_int_n, cpu_nmi_n, cpu_wait_n.
  - vec_out = 8'hFF.
  - Edge-history regs load current irq_req/nmi_req, so a level held across reset does not fire.
- Edge detect: every clk (not gated by clk_en). pending[i] set on irq_req[i] 0->1.
  - Same-cycle set and clear (ack or irq_clr): set wins.
- cpu_int_n is registered: next = ~|pending. One clk latency from the edge.
- Ack event: single-clk pulse on the first clk the qualifying condition is true; held conditions do not re-fire.
  - MODE 1 condition: ~m1_n & ~iorq_n.
  - MODE 0 condition: ~m1_n & ~mreq_n & ~rd_n & rfsh_n & cpu_a==16'h0038.
- On ack: sel = lowest-index pending bit, captured at the event.
  - irq_ack[sel] pulses; pending[sel] clears.
  - MODE 1 only: vec_out = VEC_BASE+2*sel, and vec_oe = 1 until iorq_n or m1_n deasserts.
  - No bit pending (spurious): no ack pulse; MODE 1 drives vec_out = 8'hFF with vec_oe as normal.
- NMI:
  - nmi_req 0->1 sets nmi_pend; edges while pending are ignored.
  - cpu_nmi_n = ~nmi_pend, registered.
  - Clears on first clk of ~m1_n & ~mreq_n & ~rd_n & rfsh_n & cpu_a==16'h0066; nmi_ack pulses.
  - The NMI fetch never counts as an IM1 ack.
- Wait generator:
  - On first clk of mx, load WAIT_MEM. On first clk of ix or of the MODE 1 ack condition, load WAIT_IO.
  - cpu_wait_n = 0 while count != 0. Decrement only when clk_en = 1.
  - Count forced to 0 when the triggering strobe deasserts early.
  - Refresh cycles never wait. Parameter 0: cpu_wait_n constantly 1.
- reset mid-cycle: all state returns to reset values next clk. A strobe still asserted after reset is not treated as a new event until it deasserts.

Test Plan:
- MODE 1: pulse irq_req=4'b0110, then M1&IORQ cycle -> cpu_int_n low 1 clk after edge; irq_ack=4'b0010, vec_out=8'hE2, vec_oe high for cycle; second ack -> irq_ack=4'b0100, vec_out=8'hE4, cpu_int_n high after.
- Same-cycle irq_req[0] edge and irq_clr[0] -> irq_pend[0]=1. Spurious ack with none pending -> vec_out=8'hFF, irq_ack=0.
- MODE 0: pending[3] set; fetch at 0x0038 with rfsh_n=1 -> irq_ack[3] single pulse even though strobe held 3 clks; refresh read at 0x0038 -> no ack.
- NMI: two nmi_req edges before fetch at 0x0066 -> one nmi_ack, cpu_nmi_n returns high; IM1 pending unaffected.
- WAIT_MEM=3, clk_en every 2nd clk: memory read -> cpu_wait_n low for exactly 3 clk_en ticks (6 clk). WAIT_IO=2 on IO write -> 2 ticks. mreq released after 1 tick -> wait_n high next clk.
- irq_req held high through reset -> no pending after reset. Reset asserted during vec_oe -> vec_oe=0, vec_out=8'hFF next clk.

Source files
------------

// File: rtl/z80_bus_irq_ctrl.sv
// Bus/interrupt companion for a T80s core: strobe decode, edge-latched IRQ/NMI
// requests with acknowledge detection and vector supply, and a wait-state generator.
module z80_bus_irq_ctrl #(
  parameter int unsigned NUM_IRQ  = 4,
  parameter int unsigned MODE     = 1,
  parameter logic [7:0]  VEC_BASE = 8'hE0,
  parameter int unsigned WAIT_MEM = 0,
  parameter int unsigned WAIT_IO  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic [15:0]        cpu_a,
  input  logic               cpu_mreq_n,
  input  logic               cpu_iorq_n,
  input  logic               cpu_rd_n,
  input  logic               cpu_wr_n,
  input  logic               cpu_rfsh_n,
  input  logic               cpu_m1_n,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_clr,
  input  logic               nmi_req,
  output logic               cpu_int_n,
  output logic               cpu_nmi_n,
  output logic               cpu_wait_n,
  output logic               vec_oe,
  output logic [7:0]         vec_out,
  output logic [NUM_IRQ-1:0] irq_pend,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               nmi_ack,
  output logic               mx,
  output logic               ix,
  output logic               rd,
  output logic               wr,
  output logic               m1
);

  localparam logic       IS_VEC = (MODE == 32'd1);
  localparam logic [3:0] WM     = 4'(WAIT_MEM);
  localparam logic [3:0] WI     = 4'(WAIT_IO);

  logic               fetch, ack_cond, nmi_cond, io_cond;
  logic               ack_prev, nmi_cond_prev, mx_prev, io_prev, nmi_prev;
  logic               ack_ev, nmi_ev, mem_ev, io_ev;
  logic [NUM_IRQ-1:0] irq_prev, pending, pending_nxt, irq_rise, ack_mask;
  logic               nmi_pend, nmi_pend_nxt;
  logic               any_pend;
  logic [2:0]         sel;
  logic [3:0]         wait_cnt, wait_cnt_nxt;
  logic               wait_io, wait_io_nxt, held;

  assign mx = ~cpu_mreq_n & cpu_rfsh_n;
  assign ix = ~cpu_iorq_n & cpu_m1_n;
  assign rd = ~cpu_rd_n;
  assign wr = ~cpu_wr_n;
  assign m1 = ~cpu_m1_n;

  // 0x0038 and 0x0066 are distinct, so the NMI fetch can never look like an IM1 ack
  assign fetch    = ~cpu_m1_n & ~cpu_mreq_n & ~cpu_rd_n & cpu_rfsh_n;
  assign ack_cond = IS_VEC ? (~cpu_m1_n & ~cpu_iorq_n) : (fetch & (cpu_a == 16'h0038));
  assign nmi_cond = fetch & (cpu_a == 16'h0066);
  assign io_cond  = ix | (IS_VEC & ack_cond);

  assign irq_rise = irq_req & ~irq_prev;
  assign ack_ev   = ack_cond & ~ack_prev;
  assign nmi_ev   = nmi_cond & ~nmi_cond_prev;
  assign mem_ev   = mx & ~mx_prev;
  assign io_ev    = io_cond & ~io_prev;
  assign irq_pend = pending;

  // Priority select (lowest index wins) and next pending state; new edges beat clears
  always_comb begin
    any_pend = |pending;
    sel      = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      sel = pending[i] ? 3'(i) : sel;
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_mask[i] = ack_ev & any_pend & (sel == 3'(i));
    end
    pending_nxt  = (pending & ~(irq_clr | ack_mask)) | irq_rise;
    nmi_pend_nxt = nmi_ev ? 1'b0 : (nmi_pend | (nmi_req & ~nmi_prev));
  end

  // Wait counter: reload on a new access, abort when its strobe drops, tick on clk_en
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    wait_io_nxt  = wait_io;
    held         = wait_io ? io_cond : mx;
    if (mem_ev) begin
      wait_cnt_nxt = WM;
      wait_io_nxt  = 1'b0;
    end else if (io_ev) begin
      wait_cnt_nxt = WI;
      wait_io_nxt  = 1'b1;
    end else if (!held) begin
      wait_cnt_nxt = 4'd0;
    end else if (clk_en && (wait_cnt != 4'd0)) begin
      wait_cnt_nxt = wait_cnt - 4'd1;
    end else begin
      wait_cnt_nxt = wait_cnt;
    end
  end

  // State and registered outputs; history regs track live inputs during reset
  always_ff @(posedge clk) begin
    irq_prev      <= irq_req;
    nmi_prev      <= nmi_req;
    ack_prev      <= ack_cond;
    nmi_cond_prev <= nmi_cond;
    mx_prev       <= mx;
    io_prev       <= io_cond;
    if (reset) begin
      pending    <= '0;
      nmi_pend   <= 1'b0;
      wait_cnt   <= 4'd0;
      wait_io    <= 1'b0;
      irq_ack    <= '0;
      nmi_ack    <= 1'b0;
      vec_oe     <= 1'b0;
      vec_out    <= 8'hFF;
      cpu_int_n  <= 1'b1;
      cpu_nmi_n  <= 1'b1;
      cpu_wait_n <= 1'b1;
    end else begin
      pending    <= pending_nxt;
      nmi_pend   <= nmi_pend_nxt;
      wait_cnt   <= wait_cnt_nxt;
      wait_io    <= wait_io_nxt;
      irq_ack    <= ack_mask;
      nmi_ack    <= nmi_ev & nmi_pend;
      cpu_int_n  <= ~|pending_nxt;
      cpu_nmi_n  <= ~nmi_pend_nxt;
      cpu_wait_n <= (wait_cnt_nxt == 4'd0);
      if (IS_VEC && ack_ev) begin
        vec_oe  <= 1'b1;
        vec_out <= any_pend ? (VEC_BASE + {4'd0, sel, 1'b0}) : 8'hFF;
      end else if (!ack_cond) begin
        vec_oe  <= 1'b0;
      end else begin
        vec_oe  <= vec_oe;
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_irq_ctrl.sv
// Directed bench: dut 0 runs IM1 (no waits), dut 1 runs vectored mode with
// WAIT_MEM=3 / WAIT_IO=2; acknowledge pulses are checked by a scoreboard monitor.
module tb_z80_bus_irq_ctrl;

  typedef struct packed {
    logic [3:0] ack;
    logic       nmi;
    logic [7:0] vec;
  } exp_t;

  logic        clk, reset, clk_en;
  logic [15:0] a [2];
  logic        mreq_n [2], iorq_n [2], rd_n [2], wr_n [2], rfsh_n [2], m1_n [2];
  logic [3:0]  irq_req [2], irq_clr [2];
  logic        nmi_req [2];
  logic        int_n [2], nmi_n [2], wait_n [2], voe [2], nack [2];
  logic        mxs [2], ixs [2], rds [2], wrs [2], m1s [2];
  logic [7:0]  vout [2];
  logic [3:0]  pend [2], ack [2];

  int   total = 0;
  int   bad = 0;
  logic mon_on = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  z80_bus_irq_ctrl #(.NUM_IRQ(4), .MODE(0), .VEC_BASE(8'hE0), .WAIT_MEM(0), .WAIT_IO(0)) u_im1 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .cpu_a(a[0]),
    .cpu_mreq_n(mreq_n[0]), .cpu_iorq_n(iorq_n[0]), .cpu_rd_n(rd_n[0]), .cpu_wr_n(wr_n[0]),
    .cpu_rfsh_n(rfsh_n[0]), .cpu_m1_n(m1_n[0]), .irq_req(irq_req[0]), .irq_clr(irq_clr[0]),
    .nmi_req(nmi_req[0]), .cpu_int_n(int_n[0]), .cpu_nmi_n(nmi_n[0]), .cpu_wait_n(wait_n[0]),
    .vec_oe(voe[0]), .vec_out(vout[0]), .irq_pend(pend[0]), .irq_ack(ack[0]), .nmi_ack(nack[0]),
    .mx(mxs[0]), .ix(ixs[0]), .rd(rds[0]), .wr(wrs[0]), .m1(m1s[0]));

  z80_bus_irq_ctrl #(.NUM_IRQ(4), .MODE(1), .VEC_BASE(8'hE0), .WAIT_MEM(3), .WAIT_IO(2)) u_vec (
    .clk(clk), .reset(reset), .clk_en(clk_en), .cpu_a(a[1]),
    .cpu_mreq_n(mreq_n[1]), .cpu_iorq_n(iorq_n[1]), .cpu_rd_n(rd_n[1]), .cpu_wr_n(wr_n[1]),
    .cpu_rfsh_n(rfsh_n[1]), .cpu_m1_n(m1_n[1]), .irq_req(irq_req[1]), .irq_clr(irq_clr[1]),
    .nmi_req(nmi_req[1]), .cpu_int_n(int_n[1]), .cpu_nmi_n(nmi_n[1]), .cpu_wait_n(wait_n[1]),
    .vec_oe(voe[1]), .vec_out(vout[1]), .irq_pend(pend[1]), .irq_ack(ack[1]), .nmi_ack(nack[1]),
    .mx(mxs[1]), .ix(ixs[1]), .rd(rds[1]), .wr(wrs[1]), .m1(m1s[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input int k, input logic m1n, input logic mreqn, input logic iorqn,
                     input logic rdn, input logic wrn, input logic rfshn, input logic [15:0] addr);
    m1_n[k] = m1n; mreq_n[k] = mreqn; iorq_n[k] = iorqn;
    rd_n[k] = rdn; wr_n[k] = wrn; rfsh_n[k] = rfshn; a[k] = addr;
  endtask

  task automatic idle(input int k);
    bus(k, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
  endtask

  task automatic ack_cycle(input int k);
    bus(k, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
  endtask

  task automatic push(input int k, input logic [3:0] ak, input logic n, input logic [7:0] v);
    exp_t e;
    e.ack = ak; e.nmi = n; e.vec = v;
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Strobe held for 12 clks, clk_en high on the loading edge then every 2nd clk
  task automatic wait_run(input int k, input int release_at, output int low);
    low = 0;
    clk_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (wait_n[k] == 1'b0) low++;
      clk_en = ((c % 2) == 1);
      if (c == release_at) idle(k);
    end
    clk_en = 1'b1;
  endtask

  // Monitor: every ack pulse or rising vec_oe must match the next queued expectation
  initial begin
    logic oe_d [2];
    exp_t e;
    int   qs;
    oe_d[0] = 1'b0;
    oe_d[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (mon_on && ((|ack[k]) || nack[k] || (voe[k] && !oe_d[k]))) begin
          qs = (k == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack dut%0d: got ack=%b nmi=%b vec=%h want no event",
                     k, ack[k], nack[k], vout[k]);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("irq_ack dut%0d", k), 32'(ack[k]), 32'(e.ack));
            chk($sformatf("nmi_ack dut%0d", k), 32'(nack[k]), 32'(e.nmi));
            chk($sformatf("vec_out dut%0d", k), 32'(vout[k]), 32'(e.vec));
          end
        end
        oe_d[k] = voe[k];
      end
    end
  end

  initial begin
    int low;
    reset = 1'b1;
    clk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      idle(k);
      irq_req[k] = 4'b0001;
      irq_clr[k] = 4'b0000;
      nmi_req[k] = 1'b0;
    end
    tick(2);
    for (int k = 0; k < 2; k++) begin
      chk("rst int_n", 32'(int_n[k]), 32'd1);
      chk("rst nmi_n", 32'(nmi_n[k]), 32'd1);
      chk("rst wait_n", 32'(wait_n[k]), 32'd1);
      chk("rst vec_oe", 32'(voe[k]), 32'd0);
      chk("rst vec_out", 32'(vout[k]), 32'hFF);
      chk("rst pend", 32'(pend[k]), 32'd0);
    end
    reset = 1'b0;
    tick(1);
    for (int k = 0; k < 2; k++) begin
      chk("held_req pend", 32'(pend[k]), 32'd0);
      chk("held_req int_n", 32'(int_n[k]), 32'd1);
      irq_req[k] = 4'b0000;
    end
    tick(1);
    mon_on = 1'b1;

    // Vectored mode: two pending channels served lowest first
    irq_req[1] = 4'b0110;
    tick(1);
    chk("int_n low", 32'(int_n[1]), 32'd0);
    chk("pend 0110", 32'(pend[1]), 32'h6);
    irq_req[1] = 4'b0000;
    push(1, 4'b0010, 1'b0, 8'hE2);
    ack_cycle(1);
    tick(1);
    chk("vec_oe on", 32'(voe[1]), 32'd1);
    chk("pend 0100", 32'(pend[1]), 32'h4);
    chk("iack wait_n", 32'(wait_n[1]), 32'd0);
    chk("iack ix", 32'(ixs[1]), 32'd0);
    chk("iack m1", 32'(m1s[1]), 32'd1);
    tick(2);
    chk("vec_oe held", 32'(voe[1]), 32'd1);
    idle(1);
    tick(1);
    chk("vec_oe off", 32'(voe[1]), 32'd0);
    chk("int_n still low", 32'(int_n[1]), 32'd0);
    push(1, 4'b0100, 1'b0, 8'hE4);
    ack_cycle(1);
    tick(1);
    chk("int_n released", 32'(int_n[1]), 32'd1);
    idle(1);
    tick(1);

    // Same-cycle set and clear, then software clear, then spurious ack
    irq_req[1] = 4'b0001;
    irq_clr[1] = 4'b0001;
    tick(1);
    chk("set beats clr", 32'(pend[1]), 32'h1);
    irq_req[1] = 4'b0000;
    tick(1);
    chk("clr", 32'(pend[1]), 32'h0);
    irq_clr[1] = 4'b0000;
    push(1, 4'b0000, 1'b0, 8'hFF);
    ack_cycle(1);
    tick(1);
    chk("spurious ack", 32'(ack[1]), 32'h0);
    idle(1);
    tick(1);

    // Wait generator
    bus(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234);
    #1;
    chk("mem mx", 32'(mxs[1]), 32'd1);
    chk("mem rd", 32'(rds[1]), 32'd1);
    wait_run(1, -1, low);
    chk("mem wait clks", 32'(low), 32'd6);
    idle(1);
    tick(1);
    bus(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010);
    #1;
    chk("io ix", 32'(ixs[1]), 32'd1);
    chk("io wr", 32'(wrs[1]), 32'd1);
    wait_run(1, -1, low);
    chk("io wait clks", 32'(low), 32'd4);
    idle(1);
    tick(1);
    bus(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234);
    wait_run(1, 2, low);
    chk("early release clks", 32'(low), 32'd3);
    tick(1);
    bus(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0038);
    #1;
    chk("rfsh mx", 32'(mxs[1]), 32'd0);
    tick(2);
    chk("rfsh wait_n", 32'(wait_n[1]), 32'd1);
    idle(1);
    tick(1);

    // IM1: fetch at 0x0038 held 3 clks acks once; refresh read does not
    irq_req[0] = 4'b1000;
    tick(1);
    chk("im1 pend", 32'(pend[0]), 32'h8);
    chk("im1 int_n", 32'(int_n[0]), 32'd0);
    irq_req[0] = 4'b0000;
    push(0, 4'b1000, 1'b0, 8'hFF);
    bus(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0038);
    tick(1);
    chk("im1 int_n high", 32'(int_n[0]), 32'd1);
    chk("im1 no wait", 32'(wait_n[0]), 32'd1);
    tick(2);
    chk("im1 pend cleared", 32'(pend[0]), 32'h0);
    idle(0);
    tick(1);
    irq_req[0] = 4'b0100;
    tick(1);
    irq_req[0] = 4'b0000;
    bus(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0038);
    tick(2);
    chk("rfsh no ack", 32'(pend[0]), 32'h4);
    idle(0);
    tick(1);

    // NMI: two edges before the 0x0066 fetch give one ack
    nmi_req[0] = 1'b1;
    tick(1);
    chk("nmi_n low", 32'(nmi_n[0]), 32'd0);
    nmi_req[0] = 1'b0;
    tick(1);
    nmi_req[0] = 1'b1;
    tick(1);
    nmi_req[0] = 1'b0;
    tick(1);
    push(0, 4'b0000, 1'b1, 8'hFF);
    bus(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0066);
    tick(1);
    chk("nmi_n high", 32'(nmi_n[0]), 32'd1);
    chk("nmi keeps pend", 32'(pend[0]), 32'h4);
    chk("nmi keeps int_n", 32'(int_n[0]), 32'd0);
    tick(1);
    idle(0);
    tick(1);

    // Reset while vec_oe is high; the held ack strobe must not re-fire afterwards
    irq_req[1] = 4'b1000;
    tick(1);
    irq_req[1] = 4'b0000;
    push(1, 4'b1000, 1'b0, 8'hE6);
    ack_cycle(1);
    tick(1);
    chk("pre-rst vec_oe", 32'(voe[1]), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("rst vec_oe", 32'(voe[1]), 32'd0);
    chk("rst vec_out", 32'(vout[1]), 32'hFF);
    chk("rst pend clr", 32'(pend[1]), 32'h0);
    reset = 1'b0;
    tick(1);
    irq_req[1] = 4'b0001;
    tick(1);
    irq_req[1] = 4'b0000;
    tick(1);
    chk("held ack no refire", 32'(pend[1]), 32'h1);
    idle(1);
    tick(1);
    push(1, 4'b0001, 1'b0, 8'hE0);
    ack_cycle(1);
    tick(1);
    chk("post-rst vec_out", 32'(vout[1]), 32'hE0);
    idle(1);
    tick(3);

    chk("scoreboard drained dut0", 32'(q0.size()), 32'd0);
    chk("scoreboard drained dut1", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
